// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 1280x1024@60 raster timing constants and shared types
//
// Purpose: shared constants for the VGA timing controller. It holds the default
//          1280x1024@60 Hz timing, the derived line and frame totals, the
//          coordinate and colour widths, and the sync/active bundle type that
//          travels through the alignment delay line.
// Ports:   none (package)
package vga_timing_pkg;

    localparam int COORD_W = 12;
    localparam int COLOR_W = 4;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 48;
    localparam int DEF_H_SYNC   = 112;
    localparam int DEF_H_BP     = 248;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 1024;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 38;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int MAX_IN_LATENCY = 7;

    // hs/vs are carried as "in sync pulse" (1 = asserted) regardless of the
    // pin polarity; polarity is applied only at the output register.
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } sync_bundle_t;

    localparam int BUNDLE_W = $bits(sync_bundle_t);

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - N-stage resettable shift register for the sync bundle
//
// Purpose: delays a WIDTH-bit word by N clocks. N = 0 is a pure passthrough.
//          Every stage loads RESET_VAL on a synchronous active-high reset, so a
//          reset flushes anything in flight.
// Ports:
//   i_clk    in   1      clock
//   i_reset  in   1      synchronous, active-high
//   i_data   in   WIDTH  word entering the line
//   o_data   out  WIDTH  word leaving the line, N clocks later
module sync_delay_line
    import vga_timing_pkg::*;
#(
    parameter int              N         = 0,
    parameter int              WIDTH     = BUNDLE_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (N == 0) begin : g_passthrough
            logic w_unused_ctl;
            assign w_unused_ctl = i_clk ^ i_reset;
            assign o_data       = i_data;
        end else begin : g_stages
            logic [WIDTH-1:0] r_stage [N];

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    for (int i = 0; i < N; i++) begin
                        r_stage[i] <= RESET_VAL;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < N; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_data = r_stage[N-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_controller.sv
// rtl/vga_timing_controller.sv - VGA raster timing, coordinate bus and pin driver
//
// Purpose: runs the horizontal/vertical raster counters, publishes the current
//          coordinate to the drawing blocks, realigns sync/active with the RGB
//          they return IN_LATENCY clocks later, blanks outside the visible area
//          and drives the VGA connector pins from registers.
// Ports:
//   CLK             in   1   pixel clock (108 MHz)
//   RESET           in   1   synchronous, active-high
//   VGA_RED_IN      in   4   red for the coordinate issued IN_LATENCY clocks ago
//   VGA_GREEN_IN    in   4   green, same alignment
//   VGA_BLUE_IN     in   4   blue, same alignment
//   VGA_HORZ_COORD  out  12  horizontal counter, 0..H_TOTAL-1
//   VGA_VERT_COORD  out  12  vertical counter, 0..V_TOTAL-1
//   VGA_ACTIVE      out  1   coordinate lies in the visible area
//   FRAME_START     out  1   one-clock pulse at coordinate (0,0)
//   VGA_HS          out  1   horizontal sync pin (pixel-aligned)
//   VGA_VS          out  1   vertical sync pin (pixel-aligned)
//   VGA_RED         out  4   blanked red pin
//   VGA_GREEN       out  4   blanked green pin
//   VGA_BLUE        out  4   blanked blue pin
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b1,
    parameter int IN_LATENCY = 0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [COLOR_W-1:0] VGA_RED_IN,
    input  logic [COLOR_W-1:0] VGA_GREEN_IN,
    input  logic [COLOR_W-1:0] VGA_BLUE_IN,
    output logic [COORD_W-1:0] VGA_HORZ_COORD,
    output logic [COORD_W-1:0] VGA_VERT_COORD,
    output logic               VGA_ACTIVE,
    output logic               FRAME_START,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic [COLOR_W-1:0] VGA_RED,
    output logic [COLOR_W-1:0] VGA_GREEN,
    output logic [COLOR_W-1:0] VGA_BLUE
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL >= (1 << COORD_W) || V_TOTAL >= (1 << COORD_W) ||
            IN_LATENCY < 0 || IN_LATENCY > MAX_IN_LATENCY) begin : g_bad_params
            $error("vga_timing_controller: totals must be below 4096 and IN_LATENCY within 0..7");
        end
    endgenerate

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS      = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS      = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END     = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END     = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic               SYNC_ON    = SYNC_POL;
    localparam logic               SYNC_OFF   = ~SYNC_POL;

    logic [COORD_W-1:0] r_h;
    logic [COORD_W-1:0] r_v;

    // Reset wins outright: a mid-frame reset abandons the line immediately.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign VGA_HORZ_COORD = r_h;
    assign VGA_VERT_COORD = r_v;

    logic w_active;
    logic w_hs_raw;
    logic w_vs_raw;

    assign w_active    = (r_h < H_VIS) && (r_v < V_VIS);
    assign w_hs_raw    = (r_h >= HS_START) && (r_h < HS_END);
    assign w_vs_raw    = (r_v >= VS_START) && (r_v < VS_END);
    assign VGA_ACTIVE  = w_active;
    assign FRAME_START = (r_h == '0) && (r_v == '0) && !RESET;

    // Delay the timing decode by the drawing pipeline depth so it meets the
    // RGB that belongs to the same coordinate.
    sync_bundle_t w_bundle_now;
    sync_bundle_t w_bundle_dly;

    assign w_bundle_now = '{hs: w_hs_raw, vs: w_vs_raw, active: w_active};

    sync_delay_line #(
        .N         (IN_LATENCY),
        .WIDTH     (BUNDLE_W),
        .RESET_VAL ('0)
    ) u_sync_delay (
        .i_clk   (CLK),
        .i_reset (RESET),
        .i_data  (w_bundle_now),
        .o_data  (w_bundle_dly)
    );

    // Single output register so HS, VS and RGB all move on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            VGA_HS    <= SYNC_OFF;
            VGA_VS    <= SYNC_OFF;
            VGA_RED   <= '0;
            VGA_GREEN <= '0;
            VGA_BLUE  <= '0;
        end else begin
            VGA_HS    <= w_bundle_dly.hs ? SYNC_ON : SYNC_OFF;
            VGA_VS    <= w_bundle_dly.vs ? SYNC_ON : SYNC_OFF;
            VGA_RED   <= w_bundle_dly.active ? VGA_RED_IN   : '0;
            VGA_GREEN <= w_bundle_dly.active ? VGA_GREEN_IN : '0;
            VGA_BLUE  <= w_bundle_dly.active ? VGA_BLUE_IN  : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// tb/tb_vga_timing_controller.sv - scoreboard bench for vga_timing_controller
module tb_vga_timing_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default 1280x1024 timing, IN_LATENCY=0, RGB_IN held at F/F/F
    logic        rst_a;
    logic [11:0] a_h, a_v;
    logic        a_act, a_fs, a_hs, a_vs;
    logic [3:0]  a_r, a_g, a_b;

    vga_timing_controller u_dut_a (
        .CLK(clk), .RESET(rst_a),
        .VGA_RED_IN(4'hF), .VGA_GREEN_IN(4'hF), .VGA_BLUE_IN(4'hF),
        .VGA_HORZ_COORD(a_h), .VGA_VERT_COORD(a_v), .VGA_ACTIVE(a_act),
        .FRAME_START(a_fs), .VGA_HS(a_hs), .VGA_VS(a_vs),
        .VGA_RED(a_r), .VGA_GREEN(a_g), .VGA_BLUE(a_b)
    );

    // DUT B: small raster (40x16 totals), IN_LATENCY=3, red = h[3:0] delayed 3 clocks
    localparam int BHT = 40;
    localparam int BVT = 16;
    logic        rst_b;
    logic [11:0] b_h, b_v;
    logic        b_act, b_fs, b_hs, b_vs;
    logic [3:0]  b_r, b_g, b_b;
    logic [11:0] d1, d2, d3;

    always @(posedge clk) begin
        d1 <= b_h;
        d2 <= d1;
        d3 <= d2;
    end

    vga_timing_controller #(
        .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(10),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(3), .V_BP(4),
        .SYNC_POL(1'b1), .IN_LATENCY(3)
    ) u_dut_b (
        .CLK(clk), .RESET(rst_b),
        .VGA_RED_IN(d3[3:0]), .VGA_GREEN_IN(4'hF), .VGA_BLUE_IN(4'h5),
        .VGA_HORZ_COORD(b_h), .VGA_VERT_COORD(b_v), .VGA_ACTIVE(b_act),
        .FRAME_START(b_fs), .VGA_HS(b_hs), .VGA_VS(b_vs),
        .VGA_RED(b_r), .VGA_GREEN(b_g), .VGA_BLUE(b_b)
    );

    typedef struct {
        int cyc;
        int id;
        int expv;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    string names [16] = '{"a_h", "a_v", "a_hs", "a_vs", "a_red", "a_fs", "a_act",
                          "b_h", "b_v", "b_hs", "b_vs", "b_red", "b_green", "b_blue",
                          "b_fs", "b_act"};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(int id);
        case (id)
            0:  return int'(a_h);
            1:  return int'(a_v);
            2:  return int'(a_hs);
            3:  return int'(a_vs);
            4:  return int'(a_r);
            5:  return int'(a_fs);
            6:  return int'(a_act);
            7:  return int'(b_h);
            8:  return int'(b_v);
            9:  return int'(b_hs);
            10: return int'(b_vs);
            11: return int'(b_r);
            12: return int'(b_g);
            13: return int'(b_b);
            14: return int'(b_fs);
            default: return int'(b_act);
        endcase
    endfunction

    task automatic push(int id, int e);
        exp_t x;
        x.cyc  = cyc;
        x.id   = id;
        x.expv = e;
        q.push_back(x);
    endtask

    // Monitor: compares every expectation due in the current cycle, mid-cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t x;
            int   act;
            x = q.pop_front();
            total = total + 1;
            if (x.cyc != cyc) begin
                bad = bad + 1;
                $display("FAIL %s stale entry for cycle %0d seen at cycle %0d", names[x.id], x.cyc, cyc);
            end else begin
                act = actual(x.id);
                if (act != x.expv) begin
                    bad = bad + 1;
                    $display("FAIL %s cycle %0d got=%0d expected=%0d", names[x.id], cyc, act, x.expv);
                end
            end
        end
    end

    // Expected view of DUT A, t clocks after (0,0) is first presented.
    task automatic exp_a(int t);
        int h, v, p;
        h = t % 1688;
        v = t / 1688;
        push(0, h);
        push(1, v);
        push(5, (t == 0) ? 1 : 0);
        push(6, (h < 1280 && v < 1024) ? 1 : 0);
        push(3, 0);
        if (t == 0) begin
            push(2, 0);
            push(4, 0);
        end else begin
            p = (t - 1) % 1688;
            push(2, (p >= 1328 && p < 1440) ? 1 : 0);
            push(4, (p < 1280) ? 15 : 0);
        end
    endtask

    // Expected view of DUT B, t clocks after its latest release from reset.
    task automatic exp_b(int t);
        int k, hk, vk, act;
        push(7, t % BHT);
        push(8, (t / BHT) % BVT);
        push(14, (t % (BHT * BVT) == 0) ? 1 : 0);
        push(15, ((t % BHT) < 20 && ((t / BHT) % BVT) < 8) ? 1 : 0);
        k = t - 4;
        if (k < 0) begin
            push(9, 0);
            push(10, 0);
            push(11, 0);
            push(12, 0);
            push(13, 0);
        end else begin
            hk  = k % BHT;
            vk  = (k / BHT) % BVT;
            act = (hk < 20 && vk < 8) ? 1 : 0;
            push(9, (hk >= 24 && hk < 30) ? 1 : 0);
            push(10, (vk >= 9 && vk < 12) ? 1 : 0);
            push(11, act ? (hk % 16) : 0);
            push(12, act ? 15 : 0);
            push(13, act ? 5 : 0);
        end
    endtask

    localparam int REL      = 5;
    localparam int A_LEN    = 3400;
    localparam int B_RST_AT = 853;
    localparam int B_TAIL   = 700;

    initial begin
        int base_b;
        int n_end;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        base_b = REL;
        n_end  = REL + A_LEN;
        for (int n = 1; n <= n_end; n++) begin
            @(posedge clk);
            #1;
            if (n < REL) begin
                push(0, 0); push(1, 0); push(2, 0); push(3, 0);
                push(4, 0); push(5, 0); push(6, 1);
                push(7, 0); push(8, 0); push(9, 0); push(10, 0);
                push(11, 0); push(12, 0); push(13, 0); push(14, 0);
            end else begin
                if (n == REL) begin
                    rst_a = 1'b0;
                    rst_b = 1'b0;
                end
                if (n == REL + B_RST_AT) rst_b = 1'b1;
                if (n == REL + B_RST_AT + 1) begin
                    rst_b  = 1'b0;
                    base_b = n;
                end
                exp_a(n - REL);
                if (n <= REL + B_RST_AT + 1 + B_TAIL) exp_b(n - base_b);
            end
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #2;
        if (q.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain %0d expectations left unchecked, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
